// File: rtl/fifo_uart_tx.sv
// Read-domain consumer of the async FIFO: pops a word when allowed and
// shifts it out as a UART frame (start, data LSB first, optional parity, stop).
module fifo_uart_tx #(
  parameter int DATA_WIDTH     = 8,
  parameter int PRESCALE_WIDTH = 8
) (
  input  logic                      R_CLK,
  input  logic                      R_rst,
  input  logic                      Empty,
  input  logic [DATA_WIDTH-1:0]     R_Data,
  output logic                      R_inc,
  input  logic                      tx_en,
  input  logic                      par_en,
  input  logic                      par_odd,
  input  logic [PRESCALE_WIDTH-1:0] prescale,
  output logic                      tx_out,
  output logic                      busy,
  output logic                      frame_done
);

  localparam int IDX_W = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DATA_WIDTH - 1);

  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

  state_t                    state, state_n;
  logic [DATA_WIDTH-1:0]     shift_q, shift_n;
  logic                      par_bit_q, par_bit_n;
  logic                      par_en_q, par_en_n;
  logic [PRESCALE_WIDTH-1:0] prescale_q, prescale_n;
  logic [PRESCALE_WIDTH-1:0] timer_q, timer_n;
  logic [IDX_W-1:0]          idx_q, idx_n;
  logic                      tx_n, busy_n, done_n;
  logic                      bit_end;

  assign bit_end = (timer_q == prescale_q);

  always_comb begin
    R_inc = (state == IDLE) & tx_en & ~Empty & ~R_rst;
  end

  // Outputs are registered from the next-state values so they line up with
  // the state that will be occupied after the edge.
  always_comb begin
    state_n    = state;
    shift_n    = shift_q;
    par_bit_n  = par_bit_q;
    par_en_n   = par_en_q;
    prescale_n = prescale_q;
    timer_n    = bit_end ? '0 : timer_q + PRESCALE_WIDTH'(1);
    idx_n      = idx_q;
    done_n     = 1'b0;

    case (state)
      IDLE: begin
        timer_n = '0;
        if (R_inc) begin
          state_n    = START;
          shift_n    = R_Data;
          par_bit_n  = par_odd ? ~^R_Data : ^R_Data;
          par_en_n   = par_en;
          prescale_n = prescale;
        end
      end
      START: begin
        if (bit_end) state_n = DATA;
      end
      DATA: begin
        if (bit_end) begin
          shift_n = shift_q >> 1;
          if (idx_q == LAST_IDX) begin
            idx_n   = '0;
            state_n = par_en_q ? PARITY : STOP;
          end else begin
            idx_n = idx_q + IDX_W'(1);
          end
        end
      end
      PARITY: begin
        if (bit_end) state_n = STOP;
      end
      STOP: begin
        if (bit_end) begin
          state_n = IDLE;
          done_n  = 1'b1;
        end
      end
      default: state_n = IDLE;
    endcase

    case (state_n)
      START:   tx_n = 1'b0;
      DATA:    tx_n = shift_n[0];
      PARITY:  tx_n = par_bit_n;
      default: tx_n = 1'b1;
    endcase
    busy_n = (state_n != IDLE);
  end

  always_ff @(posedge R_CLK) begin
    if (R_rst) begin
      state      <= IDLE;
      shift_q    <= '0;
      par_bit_q  <= 1'b0;
      par_en_q   <= 1'b0;
      prescale_q <= '0;
      timer_q    <= '0;
      idx_q      <= '0;
      tx_out     <= 1'b1;
      busy       <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      state      <= state_n;
      shift_q    <= shift_n;
      par_bit_q  <= par_bit_n;
      par_en_q   <= par_en_n;
      prescale_q <= prescale_n;
      timer_q    <= timer_n;
      idx_q      <= idx_n;
      tx_out     <= tx_n;
      busy       <= busy_n;
      frame_done <= done_n;
    end
  end

endmodule

// File: tb/tb_fifo_uart_tx.sv
// Scoreboard bench for fifo_uart_tx: a FIFO model feeds words, expected
// frames are queued at write time and a monitor checks each frame cycle by cycle.
module tb_fifo_uart_tx;

  logic       R_CLK = 1'b0;
  logic       R_rst = 1'b1;
  logic       Empty;
  logic [7:0] R_Data;
  logic       R_inc;
  logic       tx_en = 1'b0;
  logic       par_en = 1'b0;
  logic       par_odd = 1'b0;
  logic [7:0] prescale = 8'd0;
  logic       tx_out, busy, frame_done;

  always #5 R_CLK = ~R_CLK;

  fifo_uart_tx #(.DATA_WIDTH(8), .PRESCALE_WIDTH(8)) dut (
    .R_CLK(R_CLK), .R_rst(R_rst), .Empty(Empty), .R_Data(R_Data), .R_inc(R_inc),
    .tx_en(tx_en), .par_en(par_en), .par_odd(par_odd), .prescale(prescale),
    .tx_out(tx_out), .busy(busy), .frame_done(frame_done)
  );

  logic [7:0] mem [0:15];
  int wr_ptr = 0;
  int rd_ptr = 0;
  assign Empty  = (wr_ptr == rd_ptr);
  assign R_Data = mem[rd_ptr[3:0]];
  always @(posedge R_CLK) if (R_inc) rd_ptr <= rd_ptr + 1;

  int cycle = 0;
  always @(posedge R_CLK) cycle <= cycle + 1;

  typedef struct {
    logic [11:0] bits;
    int          nbits;
    int          p;
  } frame_t;

  frame_t exp_q[$];
  int     pop_cycle[$];
  int     checks = 0;
  int     errors = 0;
  int     pop_count = 0;
  int     done_count = 0;
  bit     in_frame = 1'b0;

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
    end
  endtask

  task automatic pushExpected(input logic [7:0] data, input int p, input bit pe, input bit pbit);
    frame_t f;
    if (pe) begin
      f.bits  = {1'b0, 1'b1, pbit, data, 1'b0};
      f.nbits = 11;
    end else begin
      f.bits  = {2'b00, 1'b1, data, 1'b0};
      f.nbits = 10;
    end
    f.p = p;
    exp_q.push_back(f);
  endtask

  task automatic applyStimulus(input logic [7:0] data, input int p, input bit pe, input bit pbit,
                               input bit push_exp);
    if (push_exp) pushExpected(data, p, pe, pbit);
    mem[wr_ptr[3:0]] = data;
    wr_ptr++;
  endtask

  task automatic step();
    @(posedge R_CLK);
    #1;
  endtask

  task automatic waitDrain(input string name);
    int k = 0;
    while ((exp_q.size() != 0 || in_frame || !Empty) && k < 2000) begin
      step();
      k++;
    end
    checkOutput({name, "_drained"}, 32'(k < 2000), 32'd1);
    repeat (3) step();
  endtask

  // One frame starting at the negedge where R_inc was seen; the tail cycle is
  // the frame_done cycle, where a back-to-back pop may already be requested.
  task automatic runFrame(output bit again);
    frame_t f;
    int     n;
    again = 1'b0;
    pop_count++;
    pop_cycle.push_back(cycle);
    if (exp_q.size() == 0) begin
      checks++;
      errors++;
      $display("[TB] FAIL unexpected_pop: got pop at cycle %0d, expected none", cycle);
      return;
    end
    f = exp_q.pop_front();
    in_frame = 1'b1;
    n = f.p * f.nbits;
    for (int j = 1; j <= n; j++) begin
      @(negedge R_CLK);
      checkOutput($sformatf("frame%0d_c%0d", pop_count, j),
                  32'({tx_out, busy, frame_done, R_inc}),
                  32'({f.bits[(j-1)/f.p], 1'b1, 1'b0, 1'b0}));
      if (R_rst) begin
        in_frame = 1'b0;
        return;
      end
    end
    @(negedge R_CLK);
    checkOutput($sformatf("frame%0d_done", pop_count), 32'({tx_out, busy, frame_done}), 32'(3'b101));
    if (frame_done) done_count++;
    again = R_inc && !R_rst;
    in_frame = 1'b0;
  endtask

  initial begin
    bit go;
    @(posedge R_CLK);
    forever begin
      @(negedge R_CLK);
      go = R_inc && !R_rst;
      if (!go) checkOutput("idle", 32'({tx_out, busy, frame_done}), 32'(3'b100));
      while (go) runFrame(go);
    end
  end

  initial begin
    #500000;
    errors++;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    int c0, d0, base;

    // reset with a word already waiting
    tx_en = 1'b1; prescale = 8'd3; par_en = 1'b0; par_odd = 1'b0;
    applyStimulus(8'hA5, 4, 1'b0, 1'b0, 1'b1);
    repeat (3) begin
      @(negedge R_CLK);
      checkOutput("reset_outputs", 32'({tx_out, busy, frame_done, R_inc}), 32'(4'b1000));
    end
    step();
    R_rst = 1'b0;
    @(negedge R_CLK);
    checkOutput("first_pop", 32'(R_inc), 32'd1);
    waitDrain("single");
    checkOutput("single_done_count", 32'(done_count), 32'd1);

    // parity
    prescale = 8'd0; par_en = 1'b1; par_odd = 1'b0;
    applyStimulus(8'h07, 1, 1'b1, 1'b1, 1'b1);
    waitDrain("par_even_07");
    par_odd = 1'b1;
    applyStimulus(8'h07, 1, 1'b1, 1'b0, 1'b1);
    waitDrain("par_odd_07");
    par_odd = 1'b0;
    applyStimulus(8'h00, 1, 1'b1, 1'b0, 1'b1);
    waitDrain("par_even_00");

    // back-to-back
    par_en = 1'b0; tx_en = 1'b0;
    step();
    applyStimulus(8'h01, 1, 1'b0, 1'b0, 1'b1);
    applyStimulus(8'h02, 1, 1'b0, 1'b0, 1'b1);
    applyStimulus(8'h03, 1, 1'b0, 1'b0, 1'b1);
    base = pop_cycle.size();
    d0 = done_count;
    tx_en = 1'b1;
    waitDrain("b2b");
    checkOutput("b2b_gap1", 32'(pop_cycle[base+1] - pop_cycle[base]), 32'd11);
    checkOutput("b2b_gap2", 32'(pop_cycle[base+2] - pop_cycle[base+1]), 32'd11);
    checkOutput("b2b_done_count", 32'(done_count - d0), 32'd3);

    // empty FIFO
    c0 = pop_count;
    repeat (50) step();
    checkOutput("empty_no_pop", 32'(pop_count - c0), 32'd0);

    // tx_en dropped during DATA
    prescale = 8'd1;
    c0 = pop_count;
    applyStimulus(8'h3C, 2, 1'b0, 1'b0, 1'b1);
    applyStimulus(8'h5A, 2, 1'b0, 1'b0, 1'b0);
    step();
    repeat (4) step();
    tx_en = 1'b0;
    repeat (40) step();
    checkOutput("txen_single_pop", 32'(pop_count - c0), 32'd1);
    pushExpected(8'h5A, 2, 1'b0, 1'b0);
    tx_en = 1'b1;
    waitDrain("txen_resume");

    // configuration change mid-frame
    prescale = 8'd2;
    applyStimulus(8'h96, 3, 1'b0, 1'b0, 1'b1);
    step();
    repeat (5) step();
    prescale = 8'd0; par_en = 1'b1; par_odd = 1'b1;
    waitDrain("cfg_change");
    par_en = 1'b0; par_odd = 1'b0;

    // reset during data bit 3
    prescale = 8'd3;
    c0 = pop_count;
    d0 = done_count;
    applyStimulus(8'hC3, 4, 1'b0, 1'b0, 1'b1);
    applyStimulus(8'h6E, 4, 1'b0, 1'b0, 1'b1);
    step();
    repeat (17) step();
    R_rst = 1'b1;
    @(negedge R_CLK);
    @(negedge R_CLK);
    checkOutput("midrst_outputs", 32'({tx_out, busy, frame_done, R_inc}), 32'(4'b1000));
    step();
    R_rst = 1'b0;
    waitDrain("midrst");
    checkOutput("midrst_pops", 32'(pop_count - c0), 32'd2);
    checkOutput("midrst_done_count", 32'(done_count - d0), 32'd1);
    checkOutput("scoreboard_empty", 32'(exp_q.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/fifo_uart_tx.md
# fifo_uart_tx

Read-side consumer for the asynchronous FIFO, clocked in the read domain. It pops one word whenever the FIFO is non-empty and transmission is enabled, then serializes that word onto a UART-style line: start bit, data LSB first, optional parity, stop bit. It drives the FIFO's `R_inc` and consumes its `Empty`/`R_Data` outputs, so a producer writing in the write domain reaches an external serial pin.

## Interface
- `DATA_WIDTH`, default 8: FIFO word width and number of data bits per frame.
- `PRESCALE_WIDTH`, default 8: width of the bit-period configuration.

- `R_CLK`, in, 1: read-domain clock; the single clock of this block.
- `R_rst`, in, 1: reset, synchronous, active-high.
- `Empty`, in, 1: FIFO empty flag; `R_Data` is the valid head word whenever it is 0.
- `R_Data`, in, DATA_WIDTH: FIFO head word, combinational from the read address.
- `R_inc`, out, 1: pop strobe; the FIFO advances on the same `R_CLK` edge.
- `tx_en`, in, 1: allows new frames to start.
- `par_en`, in, 1: 1 inserts a parity bit.
- `par_odd`, in, 1: 1 selects odd parity, 0 selects even.
- `prescale`, in, PRESCALE_WIDTH: bit period minus one, in `R_CLK` cycles.
- `tx_out`, out, 1: serial line; idles high.
- `busy`, out, 1: frame in progress.
- `frame_done`, out, 1: one-cycle pulse when a frame completes.

## Operation
- FSM states: IDLE, START, DATA, PARITY, STOP.
- `R_inc` is combinational: `R_inc = (state==IDLE) & tx_en & ~Empty & ~R_rst`.
- On the edge where `R_inc` is 1:
  - `R_Data` is latched into the shift register.
  - Parity is computed: `^data` for even, `~^data` for odd.
  - `par_en`, `par_odd` and `prescale` are latched.
  - FSM moves to START.
- Configuration inputs changing mid-frame have no effect until the next pop.
- Bit timer counts 0..latched `prescale`. When it reaches that value:
  - the timer wraps to 0;
  - the current bit ends and the FSM advances.
- `prescale`=0 gives a 1-cycle bit.
- State sequence and line levels:
  - START drives 0.
  - DATA drives the shift register LSB. The register shifts right at each bit end. A bit index counter of width clog2(DATA_WIDTH) moves to PARITY (if latched `par_en`) or STOP after bit DATA_WIDTH-1.
  - PARITY drives the latched parity bit.
  - STOP drives 1, then returns to IDLE.
- `tx_out`, `busy` and `frame_done` are registered, with no combinational path from inputs.
- `busy` is 1 in every non-IDLE state.
- `frame_done` is 1 in the first IDLE cycle after STOP.
- Back-to-back frames:
  - A pop is allowed in that same IDLE cycle.
  - Successive frames are separated by exactly one idle-high cycle.
- `tx_en` deasserted mid-frame: the current frame completes and no further pop occurs.
- `Empty`=1 in IDLE: no pop; `tx_out` stays high.
- Reset, at any time including mid-frame:
  - after the edge: state IDLE, `tx_out`=1, `busy`=0, `frame_done`=0, counters 0;
  - `R_inc`=0 while `R_rst`=1;
  - the word being sent is discarded (already popped).

## Timing
- Reset values: `tx_out`=1, `busy`=0, `frame_done`=0, `R_inc`=0.
- Let cycle 0 be the pop edge. Then:
  - the start bit occupies cycles 1..P, where P = `prescale`+1;
  - data bit k occupies cycles P(k+1)+1..P(k+2).
- Frame length N = P·(2 + DATA_WIDTH + par_en) cycles.
- `frame_done` is high in cycle N+1. The earliest next pop is the edge ending cycle N+1, so pops are spaced N+1 cycles apart.
- `R_inc` latency from `Empty` falling is 0 cycles when the FSM is in IDLE.

## Test plan
- **Reset:** hold `R_rst`=1 for 3 cycles with `Empty`=0, `tx_en`=1.
  - `R_inc`=0, `tx_out`=1, `busy`=0, `frame_done`=0 throughout.
  - First pop occurs in the cycle after release.
- **Single frame:** `prescale`=3, `par_en`=0, `R_Data`=0xA5.
  - One `R_inc` pulse.
  - `tx_out`: low for 4 cycles, then bits 1,0,1,0,0,1,0,1 for 4 cycles each, then high for 4.
  - `frame_done` high in cycle 41 only; `busy` high in cycles 1..40.
- **Parity:** `prescale`=0, `par_en`=1.
  - 0x07 even → parity bit 1; 0x07 odd → 0; 0x00 even → 0.
  - Frame is 11 cycles.
- **Back-to-back:** FIFO holds 0x01, 0x02, 0x03; `prescale`=0; `par_en`=0.
  - Three `R_inc` pulses exactly 11 cycles apart.
  - Three `frame_done` pulses.
  - Exactly one idle-high cycle between stop and next start.
- **Gating:**
  - `Empty`=1: no `R_inc` for 50 cycles.
  - `tx_en` dropped in the DATA state: the frame finishes with correct bits and no further pop.
  - `prescale` changed mid-frame: bit widths unchanged.
- **Reset mid-frame:** assert `R_rst` during data bit 3 with `prescale`=3.
  - Next cycle `tx_out`=1, `busy`=0.
  - No `frame_done`.
  - After release, the next FIFO word pops and is sent intact.
